// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and pointer arithmetic for the round-robin packet arbiter.
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  function automatic int rr_next_ptr(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational pick of the first unmasked request at or after start, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         hit,
  output logic [W-1:0] winner,
  output logic [N-1:0] winner_oh
);
  logic [N-1:0]   avail, rot;
  logic [2*N-1:0] dbl;
  logic [W-1:0]   off;
  logic [W:0]     sum;
  assign avail = req & ~mask;
  assign dbl = {avail, avail};
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = dbl[{1'b0, start} + (W+1)'(i)];
  end
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
  end
  assign hit = |rot;
  assign sum = {1'b0, start} + {1'b0, off};
  assign winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  assign winner_oh = hit ? (N'(1) << winner) : '0;
endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin arbiter that locks onto a requester for a whole packet,
// then rotates priority; its grant_idx drives a mux select.
module rr_packet_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SEL_WIDTH = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_last,
  input  logic                 out_ready,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic [N_REQ-1:0]     grant_oh,
  output logic [N_REQ-1:0]     req_ready
);
  arb_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d, grant_idx_q, grant_idx_d;
  logic [SEL_WIDTH-1:0] next_idx, pick_start, win_idx;
  logic [N_REQ-1:0]     grant_oh_q, grant_oh_d, pick_mask, win_oh;
  logic                 locked, release_pkt, hit;
  assign locked = state_q == ARB_LOCKED;
  assign next_idx = SEL_WIDTH'(rr_next_ptr(int'(grant_idx_q), N_REQ));
  assign release_pkt = locked & req[grant_idx_q] & out_ready & req_last[grant_idx_q];
  // One picker serves both paths: IDLE searches from ptr, release masks the finished requester.
  assign pick_start = release_pkt ? next_idx : ptr_q;
  assign pick_mask = release_pkt ? grant_oh_q : '0;
  rr_priority_pick #(.N(N_REQ)) u_pick (
    .req       (req),
    .mask      (pick_mask),
    .start     (pick_start),
    .hit       (hit),
    .winner    (win_idx),
    .winner_oh (win_oh)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d = grant_oh_q;
    if (!locked && hit) begin
      state_d = ARB_LOCKED;
      grant_idx_d = win_idx;
      grant_oh_d = win_oh;
    end else if (release_pkt) begin
      ptr_d = next_idx;
      state_d = hit ? ARB_LOCKED : ARB_IDLE;
      grant_idx_d = hit ? win_idx : grant_idx_q;
      grant_oh_d = hit ? win_oh : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      grant_idx_q <= '0;
      grant_oh_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q <= grant_oh_d;
    end
  end
  assign grant_valid = locked;
  assign grant_idx = grant_idx_q;
  assign grant_oh = grant_oh_q;
  assign req_ready = grant_oh_q & {N_REQ{out_ready}};
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_oh_q));
  a_valid_oh: assert property (@(posedge clk) disable iff (!rst_n) grant_valid == |grant_oh_q);
  a_idx_oh: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> grant_oh_q == (N_REQ'(1) << grant_idx_q));
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter: directed scenarios plus a randomized run against a packet-level round-robin model.
module tb_rr_packet_arbiter;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0, req_last = '0;
  logic         out_ready = 1'b0;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [N-1:0] grant_oh, req_ready;
  int checks = 0, failures = 0;
  bit m_busy;
  int m_g, m_ptr;
  rr_packet_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_last    (req_last),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh),
    .req_ready   (req_ready)
  );
  always #5 clk = ~clk;
  function automatic int pick(logic [N-1:0] r, int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction
  // Model advances on the same edge as the DUT, using the inputs currently applied.
  task automatic tick();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_ptr = 0;
    end else if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_busy = 1; m_g = w; end
    end else if (req[m_g] && out_ready && req_last[m_g]) begin
      m_ptr = (m_g + 1) % N;
      w = pick(req & ~(N'(1) << m_g), m_ptr);
      if (w >= 0) m_g = w;
      else m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; req = '0; req_last = '0; out_ready = 0;
    tick(); tick();
    rst_n = 1;
  endtask
  task automatic test_reset();
    do_reset();
    req = 4'b0100; req_last = '0; out_ready = 1;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
      failures++; $display("FAIL reset_pre_grant valid=%b idx=%0d want valid=1 idx=2", grant_valid, grant_idx);
    end
    tick();
    #3 rst_n = 0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_oh !== 4'b0000 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async valid=%b oh=%b ready=%b want 0/0000/0000", grant_valid, grant_oh, req_ready);
    end
    tick();
    rst_n = 1; req = 4'b0001;
    #1;
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL reset_idle valid=%b want 0", grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || grant_oh !== 4'b0001) begin
      failures++; $display("FAIL reset_regrant valid=%b idx=%0d oh=%b want 1/0/0001", grant_valid, grant_idx, grant_oh);
    end
  endtask
  task automatic test_rotation();
    do_reset();
    req = 4'b1111; req_last = 4'b1111; out_ready = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'(k % N) || req_ready !== (4'b0001 << (k % N))) begin
        failures++;
        $display("FAIL rotation[%0d] valid=%b idx=%0d ready=%b want 1/%0d", k, grant_valid, grant_idx, req_ready, k % N);
      end
      tick();
    end
  endtask
  task automatic test_packet_lock();
    do_reset();
    req = 4'b0110; req_last = 4'b0000; out_ready = 1;
    tick();
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
        failures++; $display("FAIL lock_beat[%0d] valid=%b idx=%0d want 1/1", b, grant_valid, grant_idx);
      end
      tick();
    end
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
      failures++; $display("FAIL lock_handoff valid=%b idx=%0d want 1/2", grant_valid, grant_idx);
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    req = 4'b0011; req_last = 4'b0000; out_ready = 1;
    tick(); tick();
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      req_last = 4'b0001;
      #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL backpressure[%0d] valid=%b idx=%0d ready=%b want 1/0/0000", c, grant_valid, grant_idx, req_ready);
      end
      tick();
    end
    out_ready = 1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL bp_resume ready=%b want 0001", req_ready);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
      failures++; $display("FAIL bp_next valid=%b idx=%0d want 1/1", grant_valid, grant_idx);
    end
  endtask
  // Grants a single-beat packet on idx 2 so that ptr ends at 3 and the arbiter is idle.
  task automatic set_ptr3();
    do_reset();
    req = 4'b0100; req_last = 4'b0100; out_ready = 1;
    tick(); tick();
  endtask
  task automatic test_wrap_mask();
    set_ptr3();
    req = 4'b1000; req_last = 4'b1000;
    #1;
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_idle0 valid=%b want 0", grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd3) begin
      failures++; $display("FAIL wrap_grant3 valid=%b idx=%0d want 1/3", grant_valid, grant_idx);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_bubble valid=%b want 0", grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd3) begin
      failures++; $display("FAIL wrap_regrant valid=%b idx=%0d want 1/3", grant_valid, grant_idx);
    end
    set_ptr3();
    req = 4'b1001; req_last = 4'b1001;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd3) begin
      failures++; $display("FAIL wrap2_grant3 valid=%b idx=%0d want 1/3", grant_valid, grant_idx);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      failures++; $display("FAIL wrap2_no_bubble valid=%b idx=%0d want 1/0", grant_valid, grant_idx);
    end
  endtask
  task automatic test_random();
    int wait_cnt[N];
    logic [N-1:0] prev_req, e_oh;
    bit pv;
    logic [1:0] pi;
    int maxw;
    do_reset();
    prev_req = '0; pv = 0; pi = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req = N'($urandom);
      req_last = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_oh = m_busy ? (N'(1) << m_g) : '0;
      checks++;
      if (grant_valid !== m_busy || grant_oh !== e_oh || req_ready !== (e_oh & {N{out_ready}})
          || (m_busy && grant_idx !== 2'(m_g))) begin
        failures++;
        $display("FAIL random[%0d] valid=%b idx=%0d oh=%b ready=%b want valid=%b idx=%0d oh=%b",
                 cyc, grant_valid, grant_idx, grant_oh, req_ready, m_busy, m_g, e_oh);
      end
      // A new grant skips every other requester that was asking at arbitration time.
      if (grant_valid === 1'b1 && (!pv || grant_idx != pi)) begin
        maxw = 0;
        for (int i = 0; i < N; i++) begin
          wait_cnt[i] = (i == int'(grant_idx)) ? 0 : (prev_req[i] ? wait_cnt[i] + 1 : 0);
          if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
        end
        checks++;
        if (maxw > N - 1) begin
          failures++; $display("FAIL fairness[%0d] max_wait=%0d want <=%0d", cyc, maxw, N - 1);
        end
      end
      pv = (grant_valid === 1'b1);
      pi = grant_idx;
      prev_req = req;
      tick();
    end
  endtask
  initial begin
    m_busy = 0; m_g = 0; m_ptr = 0;
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_wrap_mask();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
